dest_reg_bank: RTL and testbench

Destination register bank fed by the one-hot destination selector (S0/S1/S2). Captures the data bus into the currently selected destination register on each rising edge of the load strobe LDD. Tracks per-register written status. Flags illegal (non-one-hot) selects. Provides a muxed read port plus direct register taps for the datapath.

---
 rtl/dest_reg_pkg.sv | 12 +
 rtl/dest_reg_bank_ldd_edge.sv | 13 +
 rtl/dest_reg_bank.sv | 59 +++++
 tb/tb_dest_reg_bank.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dest_reg_pkg.sv
// dest_reg_pkg: shared sizes, read-select encodings and select helper for the destination register bank
package dest_reg_pkg;
  localparam int DRB_WIDTH = 4;
  localparam int DRB_NREGS = 3;
  localparam logic [1:0] RSEL_R0 = 2'd0;
  localparam logic [1:0] RSEL_R1 = 2'd1;
  localparam logic [1:0] RSEL_R2 = 2'd2;
  localparam logic [1:0] RSEL_NONE = 2'd3;
  function automatic logic isOneHot(input logic [DRB_NREGS-1:0] sel);
    return sel == 3'b001 || sel == 3'b010 || sel == 3'b100;
  endfunction
endpackage

// File: rtl/dest_reg_bank_ldd_edge.sv
// ldd_edge: rising-edge detector for the load strobe; history resets high so a held strobe cannot fire
module ldd_edge (
  input  logic CLK,
  input  logic RST,
  input  logic LDD,
  output logic ldd_rise
);
  logic lddQ;
  // strobe history, forced high in reset so release with LDD high is not an edge
  always_ff @(posedge CLK)
    lddQ <= !RST ? 1'b1 : LDD;
  assign ldd_rise = LDD & ~lddQ;
endmodule

// File: rtl/dest_reg_bank.sv
// dest_reg_bank: three destination registers loaded on LDD rising edge via one-hot select, with status flags
module dest_reg_bank
  import dest_reg_pkg::*;
#(
  parameter int WIDTH = DRB_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 S0,
  input  logic                 S1,
  input  logic                 S2,
  input  logic                 LDD,
  input  logic [WIDTH-1:0]     D,
  input  logic                 CLRV,
  input  logic [1:0]           RSEL,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     R0,
  output logic [WIDTH-1:0]     R1,
  output logic [WIDTH-1:0]     R2,
  output logic [DRB_NREGS-1:0] VALID,
  output logic                 FULL,
  output logic                 ERR
);
  logic [WIDTH-1:0] regs [DRB_NREGS];
  logic [DRB_NREGS-1:0] sel;
  logic lddRise;
  logic legal;
  logic illegal;
  ldd_edge uEdge (
    .CLK     (CLK),
    .RST     (RST),
    .LDD     (LDD),
    .ldd_rise(lddRise)
  );
  assign sel = {S2, S1, S0};
  assign legal = lddRise & isOneHot(sel);
  assign illegal = lddRise & ~isOneHot(sel);
  // capture D into the selected register; registers survive CLRV
  always_ff @(posedge CLK)
    for (int i = 0; i < DRB_NREGS; i++)
      if (!RST) regs[i] <= '0;
      else if (legal && sel[i]) regs[i] <= D;
  // status flags: a write's VALID bit and an illegal-select ERR both win over CLRV
  always_ff @(posedge CLK)
    if (!RST) begin
      VALID <= '0;
      ERR <= 1'b0;
    end else begin
      VALID <= (CLRV ? '0 : VALID) | (legal ? sel : '0);
      ERR <= (ERR & ~CLRV) | illegal;
    end
  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign Q = RSEL == RSEL_R0 ? regs[0] :
             RSEL == RSEL_R1 ? regs[1] :
             RSEL == RSEL_R2 ? regs[2] : '0;
  assign FULL = &VALID;
endmodule

// File: tb/tb_dest_reg_bank.sv
// tb_dest_reg_bank: directed vectors with hand-computed expectations for dest_reg_bank
module tb_dest_reg_bank;
  logic CLK = 1'b0;
  logic RST, S0, S1, S2, LDD, CLRV, FULL, ERR;
  logic [3:0] D, Q, R0, R1, R2;
  logic [1:0] RSEL;
  logic [2:0] VALID;
  int checks = 0;
  int errors = 0;

  dest_reg_bank #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .S0(S0), .S1(S1), .S2(S2), .LDD(LDD), .D(D),
    .CLRV(CLRV), .RSEL(RSEL), .Q(Q), .R0(R0), .R1(R1), .R2(R2),
    .VALID(VALID), .FULL(FULL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setSel(input logic [2:0] s);
    {S2, S1, S0} = s;
  endtask

  task automatic pulse(input logic [2:0] s, input logic [3:0] d);
    setSel(s);
    D = d;
    LDD = 1'b1;
    tick();
    LDD = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b0; LDD = 1'b0; CLRV = 1'b0; RSEL = 2'd0; D = 4'h0; setSel(3'b000);
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("rst_r0", R0, 4'h0);
    chk("rst_r1", R1, 4'h0);
    chk("rst_r2", R2, 4'h0);
    chk("rst_q", Q, 4'h0);
    chk("rst_valid", VALID, 3'b000);
    chk("rst_full", FULL, 1'b0);
    chk("rst_err", ERR, 1'b0);

    pulse(3'b001, 4'hA);
    chk("w0_r0", R0, 4'hA);
    chk("w0_valid", VALID, 3'b001);
    chk("w0_full", FULL, 1'b0);
    pulse(3'b010, 4'h5);
    pulse(3'b100, 4'hF);
    chk("w2_r1", R1, 4'h5);
    chk("w2_r2", R2, 4'hF);
    chk("w2_valid", VALID, 3'b111);
    chk("w2_full", FULL, 1'b1);
    RSEL = 2'd1; #1; chk("q_sel1", Q, 4'h5);
    RSEL = 2'd3; #1; chk("q_sel3", Q, 4'h0);
    RSEL = 2'd2; #1; chk("q_sel2", Q, 4'hF);
    RSEL = 2'd0; #1; chk("q_sel0", Q, 4'hA);

    setSel(3'b001); D = 4'h1; LDD = 1'b1;
    tick();
    chk("hold_first", R0, 4'h1);
    for (int i = 2; i <= 5; i++) begin
      D = 4'(i);
      tick();
    end
    chk("hold_r0", R0, 4'h1);
    LDD = 1'b0;
    tick();

    setSel(3'b000); D = 4'h7; LDD = 1'b0;
    tick();
    setSel(3'b010);
    tick();
    chk("sel_no_rise", R1, 4'h5);

    RST = 1'b0; LDD = 1'b1; setSel(3'b001); D = 4'h9;
    tick();
    RST = 1'b1;
    tick(); tick();
    chk("relhigh_valid", VALID, 3'b000);
    chk("relhigh_r0", R0, 4'h0);
    LDD = 1'b0;
    tick();

    pulse(3'b000, 4'h6);
    chk("ill0_err", ERR, 1'b1);
    chk("ill0_valid", VALID, 3'b000);
    pulse(3'b011, 4'h6);
    chk("ill3_err", ERR, 1'b1);
    chk("ill3_r0", R0, 4'h0);
    chk("ill3_r1", R1, 4'h0);
    pulse(3'b010, 4'h3);
    chk("legal_keeps_err", ERR, 1'b1);
    chk("legal_r1", R1, 4'h3);
    chk("legal_valid", VALID, 3'b010);
    pulse(3'b010, 4'hC);
    chk("ovw_r1", R1, 4'hC);
    chk("ovw_valid", VALID, 3'b010);

    CLRV = 1'b1; setSel(3'b100); D = 4'h7; LDD = 1'b1;
    tick();
    CLRV = 1'b0; LDD = 1'b0;
    chk("clrw_valid", VALID, 3'b100);
    chk("clrw_r2", R2, 4'h7);
    chk("clrw_err", ERR, 1'b0);
    chk("clrw_r1_kept", R1, 4'hC);
    tick();
    CLRV = 1'b1; setSel(3'b110); D = 4'h2; LDD = 1'b1;
    tick();
    CLRV = 1'b0; LDD = 1'b0;
    chk("clri_err", ERR, 1'b1);
    chk("clri_valid", VALID, 3'b000);
    chk("clri_r2", R2, 4'h7);
    tick();

    setSel(3'b001); D = 4'hB; LDD = 1'b1;
    tick();
    chk("mid_r0", R0, 4'hB);
    RST = 1'b0;
    tick();
    chk("mid_r0_rst", R0, 4'h0);
    chk("mid_r1_rst", R1, 4'h0);
    chk("mid_r2_rst", R2, 4'h0);
    chk("mid_valid_rst", VALID, 3'b000);
    chk("mid_err_rst", ERR, 1'b0);
    RST = 1'b1;
    tick(); tick();
    chk("mid_nowrite", VALID, 3'b000);
    LDD = 1'b0;
    tick();
    pulse(3'b001, 4'hD);
    chk("mid_rewrite", R0, 4'hD);
    chk("mid_revalid", VALID, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
